// File: rtl/transaction_pkg.sv
// Shared definitions for the transaction step responder: step codes, unit
// indices, the code-to-unit mapping and the responder state encoding.
package transaction_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned UNIT_W = 2;
    localparam int unsigned NUM_UNITS = 4;

    localparam logic [CODE_W-1:0] STEP_NONE          = 3'b000;
    localparam logic [CODE_W-1:0] STEP_VERIFY_AMOUNT = 3'b001;
    localparam logic [CODE_W-1:0] STEP_VERIFY_SIG    = 3'b010;
    localparam logic [CODE_W-1:0] STEP_MINE          = 3'b011;
    localparam logic [CODE_W-1:0] STEP_FINISH        = 3'b100;

    localparam logic [UNIT_W-1:0] UNIT_AMOUNT = 2'd0;
    localparam logic [UNIT_W-1:0] UNIT_SIG    = 2'd1;
    localparam logic [UNIT_W-1:0] UNIT_MINER  = 2'd2;
    localparam logic [UNIT_W-1:0] UNIT_FINISH = 2'd3;

    // Latched step request waiting for dispatch
    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] code;
    } pending_t;

    typedef enum logic [2:0] {
        IDLE,
        TRAVEL,
        TRAVEL_END,
        DISPATCH,
        WAIT_UNIT,
        STEP_DONE
    } resp_state_e;

    // True for the four dispatchable step codes
    function automatic logic step_valid(input logic [CODE_W-1:0] code);
        return (code == STEP_VERIFY_AMOUNT) || (code == STEP_VERIFY_SIG) ||
               (code == STEP_MINE) || (code == STEP_FINISH);
    endfunction

    // Map a step code to the datapath unit that executes it
    function automatic logic [UNIT_W-1:0] unit_idx(input logic [CODE_W-1:0] code);
        logic [UNIT_W-1:0] idx;
        case (code)
            STEP_VERIFY_SIG: idx = UNIT_SIG;
            STEP_MINE:       idx = UNIT_MINER;
            STEP_FINISH:     idx = UNIT_FINISH;
            default:         idx = UNIT_AMOUNT;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/travel_timer.sv
// Load / decrement / expire down-counter, saturating at zero.
// Ports: clock, resetn (async active-low), load + load_value (load has
// priority), dec (decrement when nonzero), expired_c (count is zero).
module travel_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         expired_c
);

    logic [W-1:0] count;

    // Counter register; never wraps below zero
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/transaction_step_responder.sv
// Responder for the transaction controller's step/travel command interface.
// Times travel phases, dispatches steps to their datapath unit and returns
// single-cycle done_travel / done_step pulses.
// Ports: clock, resetn (async active-low), step[2:0], travel[2:0],
// unit_done[3:0] in; done_travel, done_step, unit_start[3:0], travel_id[2:0],
// busy, step_error out (all registered, reset to 0).
// Optional feature: STEP_TIMEOUT_EN enables a WAIT_UNIT timeout of
// STEP_TIMEOUT cycles that forces completion and sets step_error.
module transaction_step_responder
    import transaction_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 16,
    parameter int unsigned STEP_TIMEOUT  = 1024
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [CODE_W-1:0]    step,
    input  logic [CODE_W-1:0]    travel,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 done_travel,
    output logic                 done_step,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [CODE_W-1:0]    travel_id,
    output logic                 busy,
    output logic                 step_error
);

    localparam int unsigned CNT_MAX = (TRAVEL_CYCLES > STEP_TIMEOUT) ? TRAVEL_CYCLES : STEP_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    resp_state_e       state, state_nxt;
    pending_t          pending, pending_nxt;
    logic [CODE_W-1:0] dispatch_code;
    logic [UNIT_W-1:0] unit_sel;
    logic              travel_load, travel_dec, travel_expired_c;
    logic              timeout_hit;

    travel_timer #(.W(CNT_W)) u_travel_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load       (travel_load),
        .load_value (CNT_W'(TRAVEL_CYCLES - 1)),
        .dec        (travel_dec),
        .expired_c  (travel_expired_c)
    );

`ifdef STEP_TIMEOUT_EN
    logic timeout_load, timeout_dec, timeout_expired_c;

    // Restarted on every dispatch, counts WAIT_UNIT cycles
    assign timeout_load = (state == DISPATCH);
    assign timeout_dec  = (state == WAIT_UNIT);

    travel_timer #(.W(CNT_W)) u_timeout_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load       (timeout_load),
        .load_value (CNT_W'(STEP_TIMEOUT - 1)),
        .dec        (timeout_dec),
        .expired_c  (timeout_expired_c)
    );
`endif

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, pending-step and timer control
    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        travel_load   = 1'b0;
        travel_dec    = 1'b0;
        timeout_hit   = 1'b0;
        dispatch_code = STEP_NONE;

        // A newer valid code overwrites any earlier one
        if (((state == IDLE) || (state == TRAVEL)) && step_valid(step)) begin
            pending_nxt = '{valid: 1'b1, code: step};
        end

        case (state)
            IDLE: begin
                if (travel != STEP_NONE) begin
                    state_nxt   = TRAVEL;
                    travel_load = 1'b1;
                end else if (pending_nxt.valid) begin
                    state_nxt = DISPATCH;
                end
            end
            TRAVEL: begin
                if (travel_expired_c) begin
                    state_nxt = TRAVEL_END;
                end else begin
                    travel_dec = 1'b1;
                end
            end
            TRAVEL_END: begin
                state_nxt = pending.valid ? DISPATCH : IDLE;
            end
            DISPATCH: begin
                state_nxt = WAIT_UNIT;
            end
            WAIT_UNIT: begin
                // Completion of the selected unit beats a same-cycle timeout
                if (unit_done[unit_sel]) begin
                    state_nxt = STEP_DONE;
`ifdef STEP_TIMEOUT_EN
                end else if (timeout_expired_c) begin
                    state_nxt   = STEP_DONE;
                    timeout_hit = 1'b1;
`endif
                end
            end
            STEP_DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Pending is consumed as DISPATCH is entered
        if (state_nxt == DISPATCH) begin
            dispatch_code = pending_nxt.code;
            pending_nxt   = '0;
        end
    end

    // Registered outputs, decoded from the next state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending     <= '0;
            unit_sel    <= '0;
            unit_start  <= '0;
            done_travel <= 1'b0;
            done_step   <= 1'b0;
            busy        <= 1'b0;
            travel_id   <= '0;
        end else begin
            pending     <= pending_nxt;
            done_travel <= (state_nxt == TRAVEL_END);
            done_step   <= (state_nxt == STEP_DONE);
            busy        <= (state_nxt != IDLE);
            if (state_nxt == DISPATCH) begin
                unit_sel   <= unit_idx(dispatch_code);
                unit_start <= NUM_UNITS'(1) << unit_idx(dispatch_code);
            end else begin
                unit_start <= '0;
            end
            if ((state == IDLE) && (state_nxt == TRAVEL)) begin
                travel_id <= travel;
            end else if (state_nxt != TRAVEL) begin
                travel_id <= '0;
            end
        end
    end

`ifdef STEP_TIMEOUT_EN
    // Sticky error flag for a timed-out step, cleared on the next dispatch
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            step_error <= 1'b0;
        end else if (state_nxt == DISPATCH) begin
            step_error <= 1'b0;
        end else if (timeout_hit) begin
            step_error <= 1'b1;
        end
    end
`else
    assign step_error = 1'b0;
`endif

endmodule

// File: tb/tb_transaction_step_responder.sv
// Directed bench for transaction_step_responder (TRAVEL_CYCLES=4,
// STEP_TIMEOUT=8). Timeout checks are built only with STEP_TIMEOUT_EN.
module tb_transaction_step_responder;

    logic       clock;
    logic       resetn;
    logic [2:0] step;
    logic [2:0] travel;
    logic [3:0] unit_done;
    logic       done_travel;
    logic       done_step;
    logic [3:0] unit_start;
    logic [2:0] travel_id;
    logic       busy;
    logic       step_error;

    int checks = 0;
    int errors = 0;

    transaction_step_responder #(
        .TRAVEL_CYCLES (4),
        .STEP_TIMEOUT  (8)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .step        (step),
        .travel      (travel),
        .unit_done   (unit_done),
        .done_travel (done_travel),
        .done_step   (done_step),
        .unit_start  (unit_start),
        .travel_id   (travel_id),
        .busy        (busy),
        .step_error  (step_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] all_outs();
        return {1'b0, done_travel, done_step, unit_start, travel_id, busy, step_error};
    endfunction

    initial begin
        resetn    = 1'b0;
        step      = 3'b000;
        travel    = 3'b000;
        unit_done = 4'b0000;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 12'h000);
        resetn = 1'b1;
        tick();
        chk("idle_after_reset", all_outs(), 12'h000);

        // Travel only: travel_id held 4 cycles, done_travel in cycle 5
        travel = 3'b001;
        tick();
        travel = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            chk("travel_id_active", 12'(travel_id), 12'h1);
            chk("travel_no_done", 12'(done_travel), 12'h0);
            chk("travel_no_start", 12'(unit_start), 12'h0);
            chk("travel_busy", 12'(busy), 12'h1);
            tick();
        end
        chk("travel_done_pulse", 12'(done_travel), 12'h1);
        chk("travel_id_cleared", 12'(travel_id), 12'h0);
        tick();
        chk("travel_done_single", 12'(done_travel), 12'h0);
        chk("travel_back_idle", 12'(busy), 12'h0);
        chk("travel_only_no_start", 12'(unit_start), 12'h0);

        // Travel with step: dispatch directly after TRAVEL_END
        travel = 3'b001;
        step   = 3'b001;
        tick();
        travel = 3'b000;
        step   = 3'b000;
        tick(); tick(); tick(); tick();
        chk("ts_done_travel", 12'(done_travel), 12'h1);
        chk("ts_no_start_yet", 12'(unit_start), 12'h0);
        tick();
        chk("ts_start_amount", 12'(unit_start), 12'h1);
        chk("ts_done_travel_off", 12'(done_travel), 12'h0);
        tick();
        chk("ts_start_single", 12'(unit_start), 12'h0);
        unit_done = 4'b0001;
        tick();
        unit_done = 4'b0000;
        chk("ts_done_step", 12'(done_step), 12'h1);
        tick();
        chk("ts_done_step_single", 12'(done_step), 12'h0);
        chk("ts_idle", 12'(busy), 12'h0);

        // Finish step without travel, fast path
        step = 3'b100;
        tick();
        chk("fin_start", 12'(unit_start), 12'h8);
        tick();
        chk("fin_wait_no_start", 12'(unit_start), 12'h0);
        unit_done = 4'b1000;
        tick();
        chk("fin_done_step", 12'(done_step), 12'h1);
        step      = 3'b000;
        unit_done = 4'b0000;
        tick();
        chk("fin_done_single", 12'(done_step), 12'h0);
        tick();
        chk("fin_no_redispatch", 12'(unit_start), 12'h0);
        chk("fin_idle", 12'(busy), 12'h0);

        // Invalid step code is not dispatched
        step = 3'b110;
        tick(); tick(); tick();
        chk("invalid_no_start", 12'(unit_start), 12'h0);
        chk("invalid_idle", 12'(busy), 12'h0);

        // Signature step ignores completions from other units
        step = 3'b010;
        tick();
        chk("sig_start", 12'(unit_start), 12'h2);
        step = 3'b000;
        tick();
        unit_done = 4'b0001;
        tick();
        chk("sig_ignore_amount", 12'(done_step), 12'h0);
        unit_done = 4'b0100;
        tick();
        chk("sig_ignore_miner", 12'(done_step), 12'h0);
        unit_done = 4'b1000;
        tick();
        chk("sig_ignore_finish", 12'(done_step), 12'h0);
        chk("sig_still_busy", 12'(busy), 12'h1);
        unit_done = 4'b0010;
        tick();
        unit_done = 4'b0000;
        chk("sig_done_step", 12'(done_step), 12'h1);
        tick();
        chk("sig_idle", 12'(busy), 12'h0);

        // Pending overwrite during travel; invalid code does not overwrite
        travel = 3'b101;
        step   = 3'b001;
        tick();
        travel = 3'b000;
        step   = 3'b011;
        chk("ow_travel_id", 12'(travel_id), 12'h5);
        tick();
        step = 3'b110;
        tick();
        step = 3'b000;
        tick(); tick();
        chk("ow_done_travel", 12'(done_travel), 12'h1);
        tick();
        chk("ow_start_miner", 12'(unit_start), 12'h4);
        tick();
        unit_done = 4'b0100;
        tick();
        unit_done = 4'b0000;
        chk("ow_done_step", 12'(done_step), 12'h1);
        tick();

`ifdef STEP_TIMEOUT_EN
        // Timeout after 8 WAIT_UNIT cycles sets step_error
        step = 3'b001;
        tick();
        step = 3'b000;
        chk("to_start", 12'(unit_start), 12'h1);
        tick();
        for (int i = 2; i <= 9; i++) begin
            chk("to_waiting", 12'(done_step), 12'h0);
            tick();
        end
        chk("to_done_step", 12'(done_step), 12'h1);
        chk("to_error_set", 12'(step_error), 12'h1);
        tick();
        chk("to_error_held", 12'(step_error), 12'h1);
        step = 3'b001;
        tick();
        step = 3'b000;
        chk("to_error_cleared", 12'(step_error), 12'h0);
        tick();
        for (int i = 2; i <= 9; i++) begin
            if (i == 9) unit_done = 4'b0001;
            tick();
        end
        unit_done = 4'b0000;
        chk("to_tie_done_step", 12'(done_step), 12'h1);
        chk("to_tie_no_error", 12'(step_error), 12'h0);
        tick();
`endif

        // Reset during travel
        travel = 3'b011;
        tick();
        travel = 3'b000;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_travel_async", all_outs(), 12'h000);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rst_travel_quiet", all_outs(), 12'h000);
        end

        // Reset during WAIT_UNIT; late unit_done is ignored
        step = 3'b010;
        tick();
        step = 3'b000;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_wait_async", all_outs(), 12'h000);
        tick();
        resetn    = 1'b1;
        unit_done = 4'b0010;
        tick();
        tick();
        unit_done = 4'b0000;
        chk("rst_wait_no_done", 12'(done_step), 12'h0);
        chk("rst_wait_idle", all_outs(), 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
